// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: opcodes, FSM states,
// instruction classes and datapath mux/ALU/writeback selects.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OpcR   = 7'b0110011;
    localparam logic [6:0] OpcI   = 7'b0010011;
    localparam logic [6:0] OpcL   = 7'b0000011;
    localparam logic [6:0] OpcS   = 7'b0100011;
    localparam logic [6:0] OpcB   = 7'b1100011;
    localparam logic [6:0] OpcJal = 7'b1101111;
    localparam logic [6:0] OpcLui = 7'b0110111;

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StDecode = 3'b001,
        StExec   = 3'b010,
        StMem    = 3'b011,
        StWb     = 3'b100,
        StTrap   = 3'b101
    } state_e;

    typedef enum logic [2:0] {
        ClsR   = 3'd0,
        ClsI   = 3'd1,
        ClsL   = 3'd2,
        ClsS   = 3'd3,
        ClsB   = 3'd4,
        ClsJal = 3'd5,
        ClsLui = 3'd6,
        ClsBad = 3'd7
    } instr_class_e;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcARs1   = 2'b01;
    localparam logic [1:0] SrcAOldPc = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBFour = 2'b01;
    localparam logic [1:0] SrcBImm  = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMdr    = 2'b01;
    localparam logic [1:0] WbPc     = 2'b10;

endpackage

// File: rtl/mcu_opcode_classifier.sv
// Combinational opcode classifier; disabled JAL/LUI fall into the illegal class.
module mcu_opcode_classifier
    import multicycle_control_unit_pkg::*;
#(
    parameter bit ENABLE_JAL = 1'b1,
    parameter bit ENABLE_LUI = 1'b1
) (
    input  logic [6:0]   opcode,
    output instr_class_e cls
);

    always_comb begin
        cls = ClsBad;
        case (opcode)
            OpcR:    cls = ClsR;
            OpcI:    cls = ClsI;
            OpcL:    cls = ClsL;
            OpcS:    cls = ClsS;
            OpcB:    cls = ClsB;
            OpcJal:  cls = ENABLE_JAL ? ClsJal : ClsBad;
            OpcLui:  cls = ENABLE_LUI ? ClsLui : ClsBad;
            default: cls = ClsBad;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a shared
// memory handshake, illegal-opcode and memory-wait-timeout traps.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit          ENABLE_JAL  = 1'b1,
    parameter bit          ENABLE_LUI  = 1'b1,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic       timeout,
    output logic [2:0] state_o
);

    // Count value seen on the last permitted waiting cycle.
    localparam logic [TO_W-1:0] WaitLast = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_q, state_d;
    instr_class_e    cls_q, cls_d, dec_cls;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;
    logic            wait_expired;

    mcu_opcode_classifier #(
        .ENABLE_JAL(ENABLE_JAL),
        .ENABLE_LUI(ENABLE_LUI)
    ) u_classifier (
        .opcode(opcode),
        .cls   (dec_cls)
    );

    // A late mem_ready on the final allowed cycle still wins over the trap.
    assign wait_expired = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WaitLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            cls_q     <= ClsR;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        wait_d    = '0;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            StFetch, StMem: begin
                if (mem_ready) begin
                    if (state_q == StFetch) begin
                        state_d = StDecode;
                    end else begin
                        state_d = (cls_q == ClsS) ? StFetch : StWb;
                    end
                end else if (wait_expired) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            StDecode: begin
                cls_d = dec_cls;
                if (dec_cls == ClsBad) begin
                    state_d   = StTrap;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                case (cls_q)
                    ClsL, ClsS: state_d = StMem;
                    ClsB:       state_d = StFetch;
                    ClsBad:     state_d = StTrap;
                    default:    state_d = StWb;
                endcase
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluAdd;
        reg_write  = 1'b0;
        mem_to_reg = WbAluOut;
        instr_done = 1'b0;
        // Reset gates outputs directly so mem_req drops without waiting for a clock.
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req   = 1'b1;
                    alu_src_b = SrcBFour;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                StDecode: begin
                    alu_src_a = SrcAOldPc;
                    alu_src_b = SrcBImm;
                end
                StExec: begin
                    case (cls_q)
                        ClsR: begin
                            alu_src_a = SrcARs1;
                            alu_op    = AluFunct;
                        end
                        ClsI: begin
                            alu_src_a = SrcARs1;
                            alu_src_b = SrcBImm;
                            alu_op    = AluFunct;
                        end
                        ClsL, ClsS: begin
                            alu_src_a = SrcARs1;
                            alu_src_b = SrcBImm;
                        end
                        ClsB: begin
                            alu_src_a  = SrcARs1;
                            alu_op     = AluSub;
                            pc_src     = 1'b1;
                            pc_write   = branch_taken;
                            instr_done = 1'b1;
                        end
                        ClsJal: begin
                            pc_write = 1'b1;
                            pc_src   = 1'b1;
                        end
                        ClsLui: begin
                            alu_src_a = SrcAZero;
                            alu_src_b = SrcBImm;
                        end
                        default: ;
                    endcase
                end
                StMem: begin
                    mem_req    = 1'b1;
                    i_or_d     = 1'b1;
                    mem_we     = (cls_q == ClsS);
                    instr_done = mem_ready && (cls_q == ClsS);
                end
                StWb: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    if (cls_q == ClsL) begin
                        mem_to_reg = WbMdr;
                    end else if (cls_q == ClsJal) begin
                        mem_to_reg = WbPc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed tables, per-instruction cycle traces
// built from the instruction-class rules, random instruction streams and trap cases.
module tb_multicycle_control_unit;

    localparam logic [6:0] OpR   = 7'b0110011;
    localparam logic [6:0] OpI   = 7'b0010011;
    localparam logic [6:0] OpL   = 7'b0000011;
    localparam logic [6:0] OpS   = 7'b0100011;
    localparam logic [6:0] OpB   = 7'b1100011;
    localparam logic [6:0] OpJal = 7'b1101111;
    localparam logic [6:0] OpLui = 7'b0110111;

    // Output bundle, MSB first, matching the wire slicing below.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        logic       reg_write;
        logic [1:0] mtr;
        logic       done;
        logic       ill;
        logic       to;
        logic [2:0] st;
    } out_t;

    typedef struct {
        logic       rdy;
        logic       bt;
        logic [6:0] opc;
        out_t       exp;
    } step_t;

    localparam out_t DecodeV  = 21'b0_0_0_0_0_0_10_10_00_0_00_0_0_0_001;
    localparam out_t TrapIllV = 21'b0_0_0_0_0_0_00_00_00_0_00_0_1_0_101;
    localparam out_t TrapToV  = 21'b0_0_0_0_0_0_00_00_00_0_00_0_0_1_101;
    localparam out_t LoadMemV = 21'b1_0_1_0_0_0_00_00_00_0_00_0_0_0_011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    wire [20:0] oa, ob, oc;

    int total = 0;
    int bad   = 0;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .ENABLE_JAL(1'b1), .ENABLE_LUI(1'b1), .MEM_TIMEOUT(16), .TO_W(5)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(oa[20]), .mem_we(oa[19]), .i_or_d(oa[18]),
        .ir_write(oa[17]), .pc_write(oa[16]), .pc_src(oa[15]), .alu_src_a(oa[14:13]),
        .alu_src_b(oa[12:11]), .alu_op(oa[10:9]), .reg_write(oa[8]), .mem_to_reg(oa[7:6]),
        .instr_done(oa[5]), .illegal(oa[4]), .timeout(oa[3]), .state_o(oa[2:0])
    );

    multicycle_control_unit #(
        .ENABLE_JAL(1'b0), .ENABLE_LUI(1'b1), .MEM_TIMEOUT(16), .TO_W(5)
    ) dut_nojal (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(ob[20]), .mem_we(ob[19]), .i_or_d(ob[18]),
        .ir_write(ob[17]), .pc_write(ob[16]), .pc_src(ob[15]), .alu_src_a(ob[14:13]),
        .alu_src_b(ob[12:11]), .alu_op(ob[10:9]), .reg_write(ob[8]), .mem_to_reg(ob[7:6]),
        .instr_done(ob[5]), .illegal(ob[4]), .timeout(ob[3]), .state_o(ob[2:0])
    );

    multicycle_control_unit #(
        .ENABLE_JAL(1'b1), .ENABLE_LUI(1'b1), .MEM_TIMEOUT(4), .TO_W(3)
    ) dut_to (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(oc[20]), .mem_we(oc[19]), .i_or_d(oc[18]),
        .ir_write(oc[17]), .pc_write(oc[16]), .pc_src(oc[15]), .alu_src_a(oc[14:13]),
        .alu_src_b(oc[12:11]), .alu_op(oc[10:9]), .reg_write(oc[8]), .mem_to_reg(oc[7:6]),
        .instr_done(oc[5]), .illegal(oc[4]), .timeout(oc[3]), .state_o(oc[2:0])
    );

    task automatic check(input string name, input out_t got, input out_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic out_t fetch_v(input logic rdy);
        out_t e = '0;
        e.mem_req  = 1'b1;
        e.b        = 2'b01;
        e.ir_write = rdy;
        e.pc_write = rdy;
        return e;
    endfunction

    // Appends the expected cycle-by-cycle trace of one instruction to q.
    task automatic add_instr(input logic [6:0] opc, input int fw, input int mw, input logic bt);
        step_t s;
        out_t  e;
        bit is_l = (opc == OpL);
        bit is_s = (opc == OpS);
        bit is_b = (opc == OpB);
        for (int i = 0; i <= fw; i++) begin
            s.rdy = (i == fw); s.bt = 1'($urandom); s.opc = 7'($urandom);
            s.exp = fetch_v(s.rdy);
            q.push_back(s);
        end
        s.rdy = 1'($urandom); s.bt = 1'($urandom); s.opc = opc; s.exp = DecodeV;
        q.push_back(s);
        e = '0; e.st = 3'd2;
        case (opc)
            OpR:      begin e.a = 2'b01; e.b = 2'b00; e.op = 2'b10; end
            OpI:      begin e.a = 2'b01; e.b = 2'b10; e.op = 2'b10; end
            OpL, OpS: begin e.a = 2'b01; e.b = 2'b10; end
            OpB: begin
                e.a = 2'b01; e.op = 2'b01; e.pc_src = 1'b1; e.pc_write = bt; e.done = 1'b1;
            end
            OpJal:    begin e.pc_write = 1'b1; e.pc_src = 1'b1; end
            OpLui:    begin e.a = 2'b11; e.b = 2'b10; end
            default: ;
        endcase
        s.rdy = 1'($urandom); s.bt = is_b ? bt : 1'($urandom); s.opc = 7'($urandom); s.exp = e;
        q.push_back(s);
        if (is_l || is_s) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.st = 3'd3; e.mem_req = 1'b1; e.i_or_d = 1'b1; e.mem_we = is_s;
                s.rdy = (i == mw); s.bt = 1'($urandom); s.opc = 7'($urandom);
                e.done = s.rdy && is_s;
                s.exp = e;
                q.push_back(s);
            end
        end
        if (!is_s && !is_b) begin
            e = '0; e.st = 3'd4; e.reg_write = 1'b1; e.done = 1'b1;
            e.mtr = is_l ? 2'b01 : (opc == OpJal) ? 2'b10 : 2'b00;
            s.rdy = 1'($urandom); s.bt = 1'($urandom); s.opc = 7'($urandom); s.exp = e;
            q.push_back(s);
        end
    endtask

    // Applies the first n queued steps (all if n < 0) to the main DUT, then clears q.
    task automatic run_trace(input string name, input int n);
        int lim = (n < 0) ? q.size() : n;
        for (int i = 0; i < lim; i++) begin
            mem_ready = q[i].rdy; branch_taken = q[i].bt; opcode = q[i].opc;
            #1;
            check($sformatf("%s[%0d]", name, i), oa, q[i].exp);
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'h00;
        #1;
        check("reset_outputs", oa, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

    initial begin
        step_t rtab[5];
        logic [6:0] legal[7];
        legal = '{OpR, OpI, OpL, OpS, OpB, OpJal, OpLui};
        rtab[0] = '{1'b1, 1'b0, 7'h00, 21'b1_0_0_1_1_0_00_01_00_0_00_0_0_0_000};
        rtab[1] = '{1'b1, 1'b0, OpR,   21'b0_0_0_0_0_0_10_10_00_0_00_0_0_0_001};
        rtab[2] = '{1'b1, 1'b0, 7'h7f, 21'b0_0_0_0_0_0_01_00_10_0_00_0_0_0_010};
        rtab[3] = '{1'b1, 1'b0, 7'h00, 21'b0_0_0_0_0_0_00_00_00_1_00_1_0_0_100};
        rtab[4] = '{1'b1, 1'b0, 7'h00, 21'b1_0_0_1_1_0_00_01_00_0_00_0_0_0_000};

        mem_ready = 1'b0; branch_taken = 1'b0; opcode = 7'h00;
        #2;
        @(negedge clk);
        do_reset();

        foreach (rtab[i]) q.push_back(rtab[i]);
        run_trace("rtype", -1);

        do_reset();
        add_instr(OpL, 2, 2, 1'b0);
        run_trace("load_wait", -1);

        add_instr(OpS, 0, 1, 1'b0);
        add_instr(OpB, 0, 0, 1'b1);
        add_instr(OpB, 1, 0, 1'b0);
        add_instr(OpJal, 0, 0, 1'b0);
        add_instr(OpLui, 0, 0, 1'b0);
        add_instr(OpI, 1, 0, 1'b0);
        run_trace("mix", -1);

        repeat (40) begin
            add_instr(legal[$urandom_range(0, 6)], int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom));
        end
        run_trace("random", -1);

        // Illegal opcode: trap is absorbing until reset.
        do_reset();
        q.push_back('{1'b1, 1'b0, 7'h00, fetch_v(1'b1)});
        q.push_back('{1'b0, 1'b0, 7'h7f, DecodeV});
        run_trace("illegal_entry", -1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom); branch_taken = 1'($urandom); opcode = 7'($urandom);
            #1;
            check($sformatf("illegal_hold[%0d]", i), oa, TrapIllV);
            @(negedge clk);
        end
        do_reset();
        mem_ready = 1'b0;
        #1;
        check("illegal_cleared", oa, fetch_v(1'b0));
        @(negedge clk);

        // JAL with JAL disabled traps as illegal.
        do_reset();
        mem_ready = 1'b1;
        #1;
        check("nojal_fetch", ob, fetch_v(1'b1));
        @(negedge clk);
        opcode = OpJal;
        #1;
        check("nojal_decode", ob, DecodeV);
        @(negedge clk);
        #1;
        check("nojal_trap", ob, TrapIllV);
        @(negedge clk);

        // Fetch timeout after four waiting cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = 1'b0;
            #1;
            check($sformatf("to_wait[%0d]", i), oc, fetch_v(1'b0));
            @(negedge clk);
        end
        #1;
        check("to_trap", oc, TrapToV);
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("to_trap_hold", oc, TrapToV);
        @(negedge clk);

        // mem_ready on the last allowed cycle beats the timeout.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            check($sformatf("to_late_ready[%0d]", i), oc, fetch_v(i == 3));
            @(negedge clk);
        end
        opcode = OpR;
        #1;
        check("to_ready_wins", oc, DecodeV);
        @(negedge clk);

        // Reset mid-MEM drops mem_req at once and resumes in FETCH.
        do_reset();
        add_instr(OpL, 0, 5, 1'b0);
        run_trace("mid_mem", 5);
        mem_ready = 1'b0;
        #1;
        check("mid_mem_req", oa, LoadMemV);
        #1;
        rst = 1'b1;
        #1;
        check("rst_drops_req", oa, '0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("resume_fetch", oa, fetch_v(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RISC-V main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a ready/request handshake to a shared instruction/data memory.
- Adds JAL and LUI classes, illegal-opcode trapping and a memory-wait timeout.
- Drives the datapath muxes, PC/IR write enables and register-file write; sits between the IR opcode field and the multi-cycle datapath.

Parameters:
- ENABLE_JAL, 1, when 0 the JAL opcode is treated as illegal.
- ENABLE_LUI, 1, when 0 the LUI opcode is treated as illegal.
- MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in FETCH or MEM before trapping; 0 disables the timeout.
- TO_W, 5, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- opcode  in  7  instr[6:0] from the IR; valid from DECODE onward.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  ALU comparison result for the B-type condition.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid with mem_req.
- i_or_d  out  1  address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR and the old-PC register.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = oldPC, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = imm.
- alu_op  out  2  ALU op class: 00 = add, 01 = sub/compare, 10 = funct-decoded.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  2  writeback source: 00 = ALUOut, 01 = MDR, 10 = PC (link).
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal  out  1  sticky: illegal opcode trapped.
- timeout  out  1  sticky: memory-wait timeout trapped.
- state_o  out  3  current state code, for debug.

Behaviour:
- Reset is asynchronous and active-high on rst.
  - state = FETCH (000); wait counter, class register, illegal and timeout are cleared.
  - While rst is high, every strobe and select output is 0.
- State encodings: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, TRAP=101. Unused codes go to TRAP.
- Outputs are combinational from state plus mem_ready/branch_taken. Unlisted outputs are 0 in every state.
- FETCH:
  - Drives mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - When mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE. Otherwise stay.
- DECODE:
  - Drives alu_src_a=10, alu_src_b=10, alu_op=00, which precomputes the branch/JAL target into ALUOut.
  - Opcode classes: R=0110011, I=0010011, L=0000011, S=0100011, B=1100011, JAL=1101111, LUI=0110111.
  - Classify the opcode into a registered class. Legal class → EXEC. Any other opcode, or a disabled JAL/LUI → TRAP with illegal set.
- EXEC, by class:
  - R: alu_src_a=01, alu_src_b=00, alu_op=10 → WB.
  - I: alu_src_a=01, alu_src_b=10, alu_op=10 → WB.
  - L/S: alu_src_a=01, alu_src_b=10, alu_op=00 → MEM.
  - B: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=1, pc_write=branch_taken, instr_done=1 → FETCH.
  - JAL: pc_write=1, pc_src=1 → WB (link).
  - LUI: alu_src_a=11, alu_src_b=10, alu_op=00 → WB.
- MEM:
  - Drives mem_req=1, i_or_d=1, mem_we=1 for S.
  - When mem_ready: L → WB; S → FETCH with instr_done=1.
  - mem_we must stay stable for the whole request.
- WB:
  - reg_write=1 and instr_done=1 → FETCH.
  - mem_to_reg = 01 for L, 10 for JAL, 00 otherwise.
- Wait counter:
  - Cleared on entry to FETCH/MEM and whenever mem_ready=1.
  - Increments on each FETCH/MEM cycle with mem_ready=0.
  - When MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with mem_ready still 0 → TRAP with timeout set. mem_ready arriving in that same cycle wins: no trap.
- TRAP:
  - Absorbing: all strobes 0, mem_req 0.
  - illegal and timeout hold until rst.
- Reset mid-operation (e.g. mid-MEM): mem_req drops asynchronously; execution resumes in FETCH after release.
- The opcode input is only sampled in DECODE; changes in later states are ignored.

Decomposition:
- Shared package/defines (`defines.vh`-style) holds:
  - opcode constants;
  - state encodings;
  - ALU-op, mux-select and writeback-select encodings;
  - class enum {R, I, L, S, B, JAL, LUI, BAD}.
- One sub-module, mcu_opcode_classifier: combinational, 7-bit opcode plus enable parameters in, 3-bit class out. Reused by the decode and illegal logic.

Test Plan:
- R-type 0110011 with mem_ready tied 1: states 000→001→010→100→000; reg_write=1 and instr_done=1 in cycle 4 only; mem_to_reg=00.
- Load 0000011, mem_ready asserted 2 cycles late in FETCH and in MEM:
  - mem_req high 3 cycles in each of FETCH and MEM; i_or_d=1 only in MEM;
  - then WB with mem_to_reg=01; 9 cycles total.
- Store then branch:
  - S retires from MEM with mem_we=1 and no reg_write.
  - B with branch_taken=1 gives pc_write=1, pc_src=1; with branch_taken=0, pc_write=0; both retire in EXEC.
- JAL 1101111 with ENABLE_JAL=1: pc_write=1 in EXEC, then WB mem_to_reg=10. Same opcode with ENABLE_JAL=0: TRAP, illegal=1.
- Opcode 1111111: TRAP from DECODE; illegal stays 1 and all strobes 0 for 20 cycles; rst clears it.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: TRAP with timeout=1 after 4 waiting cycles. rst asserted mid-MEM (load) drops mem_req immediately; after release state_o=000.
